// File: rtl/image_block_sequencer.sv
// image_block_sequencer
//   Capture/readout controller for the luma frame buffer. A start command arms
//   one frame capture (cap_en high until the writer reports cap_done), then the
//   frozen buffer is walked in 8x8 blocks in raster order. Each block is fetched
//   with one read per cycle and presented downstream as a 512-bit word over a
//   valid/ready handshake. Status and control are exposed on a small Avalon slave.
//   Optional feature macro: IMG_BLOCK_SEQ_IRQ_EN adds an irq output that is set
//   when the last block has been handed off.
module image_block_sequencer #(
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 224,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              cap_en,
  input  logic              cap_done,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [511:0]      blk_data,
  output logic [9:0]        blk_index
`ifdef IMG_BLOCK_SEQ_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int BLK_X = IMG_W / 8;
  localparam int BLK_Y = IMG_H / 8;
  localparam int BX_W  = (BLK_X > 1) ? $clog2(BLK_X) : 1;
  localparam int BY_W  = (BLK_Y > 1) ? $clog2(BLK_Y) : 1;
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    FETCH   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [6:0]      fcnt_reg;       // read slot within the block; 64 is the final capture-only cycle
  logic [BX_W-1:0] bx_reg;
  logic [BY_W-1:0] by_reg;
  logic [9:0]      blk_index_reg;
  logic [9:0]      count_reg;
  logic            done_reg;
  logic            irq_bit;

  // Command decode; abort overrides a start written in the same word
  logic start_cmd, abort_cmd, clear_cmd, start_ok, xfer, last_blk, fetch_end, done_set;
  assign start_cmd = wr_en && (addr == 2'd0) && writedata[0];
  assign abort_cmd = wr_en && (addr == 2'd0) && writedata[1];
  assign clear_cmd = wr_en && (addr == 2'd3);
  assign start_ok  = start_cmd && !abort_cmd && ((state_reg == IDLE) || (state_reg == DONE));
  assign xfer      = (state_reg == PRESENT) && blk_ready;
  assign last_blk  = (bx_reg == BX_W'(BLK_X - 1)) && (by_reg == BY_W'(BLK_Y - 1));
  assign fetch_end = (state_reg == FETCH) && (fcnt_reg == 7'd64);
  assign done_set  = (state_reg != DONE) && (state_next == DONE);

  // Only bits 1:0 of the control word carry meaning
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:2];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next = state_reg;
    cap_en     = 1'b0;
    blk_valid  = 1'b0;
    case (state_reg)
      IDLE:    if (start_ok) state_next = ARM;
      ARM: begin
        cap_en = 1'b1;
        if (cap_done) state_next = FETCH;
      end
      FETCH:   if (fetch_end) state_next = PRESENT;
      PRESENT: begin
        blk_valid = 1'b1;
        if (blk_ready) state_next = last_blk ? DONE : FETCH;
      end
      DONE:    if (start_ok) state_next = ARM;
      default: state_next = IDLE;
    endcase
    if (abort_cmd) state_next = IDLE;
  end

  // Read address: row r = fcnt[5:3], column c = fcnt[2:0] inside the current block
  logic [ADDR_W-1:0] pix_row, pix_col;
  always_comb begin
    pix_row     = ADDR_W'({by_reg, fcnt_reg[5:3]});
    pix_col     = ADDR_W'({bx_reg, fcnt_reg[2:0]});
    mem_rd_addr = '0;
    if ((state_reg == FETCH) && !fcnt_reg[6]) mem_rd_addr = pix_row * IMG_W_A + pix_col;
  end

  // Fetch slot counter, block position and transfer count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_reg      <= '0;
      bx_reg        <= '0;
      by_reg        <= '0;
      blk_index_reg <= '0;
      count_reg     <= '0;
    end else begin
      if ((state_reg == FETCH) && (state_next == FETCH)) fcnt_reg <= fcnt_reg + 7'd1;
      else                                               fcnt_reg <= '0;
      if (start_ok) begin
        bx_reg        <= '0;
        by_reg        <= '0;
        blk_index_reg <= '0;
        count_reg     <= '0;
      end else if (xfer) begin
        count_reg <= count_reg + 10'd1;
        // The final block leaves its index in place for status reads
        if (!last_blk) begin
          blk_index_reg <= blk_index_reg + 10'd1;
          if (bx_reg == BX_W'(BLK_X - 1)) begin
            bx_reg <= '0;
            by_reg <= by_reg + BY_W'(1);
          end else begin
            bx_reg <= bx_reg + BX_W'(1);
          end
        end
      end
    end
  end

  // Lane capture: data for read slot k arrives while fcnt = k+1
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_lane
      logic [7:0] lane_reg;
      // Capture one pixel into this lane when its read data returns
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                               lane_reg <= '0;
        else if ((state_reg == FETCH) && (fcnt_reg == 7'(gi + 1))) lane_reg <= mem_rd_data;
      end
      assign blk_data[8*gi +: 8] = lane_reg;
    end
  endgenerate

  assign blk_index = blk_index_reg;

  // Done flag: entry into DONE takes priority over a clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       done_reg <= 1'b0;
    else if (done_set)               done_reg <= 1'b1;
    else if (clear_cmd || start_ok)  done_reg <= 1'b0;
  end

`ifdef IMG_BLOCK_SEQ_IRQ_EN
  logic irq_reg;
  // Interrupt: raised with done, dropped by clear, start or abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   irq_reg <= 1'b0;
    else if (done_set)                           irq_reg <= 1'b1;
    else if (clear_cmd || start_ok || abort_cmd) irq_reg <= 1'b0;
  end
  assign irq     = irq_reg;
  assign irq_bit = irq_reg;
`else
  assign irq_bit = 1'b0;
`endif

  // Avalon read mux, zero when not reading
  always_comb begin
    readdata = '0;
    if (rd_en) begin
      case (addr)
        2'd0: readdata = {29'b0, state_reg};
        2'd1: readdata = {29'b0, irq_bit, done_reg,
                          (state_reg != IDLE) && (state_reg != DONE)};
        2'd2: readdata = {22'b0, count_reg};
        default: readdata = {22'b0, blk_index_reg};
      endcase
    end
  end

endmodule
